// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default widths for the multi-port register file
package regfile_pkg;

    typedef enum logic {
        CLR_IDLE,
        CLR_SWEEP
    } clr_state_t;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

endpackage

// File: rtl/regfile_clr_seq.sv
// rtl/regfile_clr_seq.sv - clear sequencer: walks every register index once, writing zero
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic              clr_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    clr_state_t      state, state_nxt;
    logic [ADDR_W:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLR_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // clr_req is only looked at in IDLE, so a request mid-sweep never restarts it
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLR_IDLE: begin
                if (clr_req) begin
                    state_nxt = CLR_SWEEP;
                    cnt_nxt   = '0;
                end
            end
            CLR_SWEEP: begin
                cnt_nxt = cnt + (ADDR_W + 1)'(1);
                if (cnt == LAST_IDX) begin
                    state_nxt = CLR_IDLE;
                end
            end
            default: state_nxt = CLR_IDLE;
        endcase
    end

    assign sweep_we   = (state == CLR_SWEEP);
    assign sweep_addr = cnt[ADDR_W-1:0];
    assign clr_busy   = (state == CLR_SWEEP);

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with registered reads, bypass and clear sweep
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     clr_req,
    output logic                     clr_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_addr;
    logic              wr_ok;

    regfile_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req    (clr_req),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr),
        .clr_busy   (clr_busy)
    );

    // external writes vanish during a sweep and never land in register 0 when it is hardwired
    assign wr_ok = wr_en && !clr_busy && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (sweep_we) begin
            mem[sweep_addr] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              zero_hit;
        logic              byp_hit;
        logic              take;
        logic [DATA_W-1:0] rd_q;
        logic              rd_v;

        assign addr     = rd_addr[p*ADDR_W +: ADDR_W];
        assign zero_hit = (ZERO_REG != 0) && (addr == '0);
        assign byp_hit  = (BYPASS != 0) && wr_ok && (wr_addr == addr);
        assign take     = rd_en[p] && !clr_busy;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
                rd_v <= 1'b0;
            end else begin
                rd_v <= take;
                if (take) begin
                    rd_q <= zero_hit ? '0 : (byp_hit ? wr_data : mem[addr]);
                end
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = rd_q;
        assign rd_valid[p]                 = rd_v;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp in two parameter configurations
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rd_en;
    logic [5:0]  rd_addr;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        clr_req;

    // config A: bypass on, no zero register; config B: bypass off, zero register
    logic [15:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_valid_a, rd_valid_b;
    logic        clr_busy_a, clr_busy_b;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .BYPASS(1), .ZERO_REG(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .clr_busy(clr_busy_a)
    );

    regfile_mp #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .clr_busy(clr_busy_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // behavioural model: register contents, expected outputs, sweep cycles remaining
    logic [7:0] mem   [2][8];
    logic [7:0] exp_d [2][2];
    logic [1:0] exp_v [2];
    int         sweep_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < 8; i++) mem[c][i] = 8'h00;
                exp_d[c][0] = 8'h00;
                exp_d[c][1] = 8'h00;
                exp_v[c]    = 2'b00;
            end
            sweep_left = 0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                bit byp, zr;
                byp = (c == 0);
                zr  = (c == 1);
                for (int p = 0; p < 2; p++) begin
                    int a;
                    a = int'(rd_addr[p*3 +: 3]);
                    if (rd_en[p] && sweep_left == 0) begin
                        exp_v[c][p] = 1'b1;
                        if (zr && a == 0)                                  exp_d[c][p] = 8'h00;
                        else if (byp && wr_en && int'(wr_addr) == a)       exp_d[c][p] = wr_data;
                        else                                               exp_d[c][p] = mem[c][a];
                    end else begin
                        exp_v[c][p] = 1'b0;
                    end
                end
                if (sweep_left > 0)                    mem[c][8 - sweep_left] = 8'h00;
                else if (wr_en && !(zr && wr_addr == 0)) mem[c][wr_addr] = wr_data;
            end
            if (sweep_left > 0) sweep_left--;
            else if (clr_req)   sweep_left = 8;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("a_rd_data",  32'(rd_data_a),  32'({exp_d[0][1], exp_d[0][0]}));
            chk("a_rd_valid", 32'(rd_valid_a), 32'(exp_v[0]));
            chk("a_clr_busy", 32'(clr_busy_a), 32'(sweep_left > 0));
            chk("b_rd_data",  32'(rd_data_b),  32'({exp_d[1][1], exp_d[1][0]}));
            chk("b_rd_valid", 32'(rd_valid_b), 32'(exp_v[1]));
            chk("b_clr_busy", 32'(clr_busy_b), 32'(sweep_left > 0));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rd_en = 2'b00; rd_addr = 6'd0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00; clr_req = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        idle_inputs();
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cyc();
        idle_inputs();
    endtask

    task automatic sweep_len(input string name, input bit poke_mid, output int busy_cycles);
        int guard;
        busy_cycles = 0;
        guard = 0;
        while (clr_busy_a && guard < 20) begin
            busy_cycles++;
            guard++;
            idle_inputs();
            if (poke_mid && busy_cycles == 3) begin
                wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h55;
                rd_en = 2'b11; rd_addr = {3'd1, 3'd1};
            end
            cyc();
            if (poke_mid && busy_cycles == 3) begin
                chk({name, "_mid_valid"}, 32'(rd_valid_a), 32'h0);
            end
        end
        idle_inputs();
        chk({name, "_busy_len"}, busy_cycles, 8);
    endtask

    initial begin
        int n;
        idle_inputs();
        rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        chk("reset_valid", 32'(rd_valid_a), 32'h0);
        chk("reset_data",  32'(rd_data_a),  32'h0);
        chk("reset_busy",  32'(clr_busy_a), 32'h0);

        // reset mid-run, then read r3/r5
        do_write(3'd3, 8'h33);
        do_write(3'd5, 8'h55);
        #2 rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        rd_en = 2'b11; rd_addr = {3'd5, 3'd3};
        cyc();
        chk("rst_read_data",  32'(rd_data_a),  32'h0000);
        chk("rst_read_valid", 32'(rd_valid_a), 32'h3);
        idle_inputs();

        // write then read latency, hold on rd_en drop
        do_write(3'd2, 8'hA5);
        rd_en = 2'b01; rd_addr = {3'd0, 3'd2};
        cyc();
        chk("lat_data",  32'(rd_data_a[7:0]), 32'hA5);
        chk("lat_valid", 32'(rd_valid_a),     32'h1);
        idle_inputs();
        cyc();
        chk("hold_valid", 32'(rd_valid_a),     32'h0);
        chk("hold_data",  32'(rd_data_a[7:0]), 32'hA5);

        // bypass versus old value
        do_write(3'd4, 8'h11);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h22;
        rd_en = 2'b01; rd_addr = {3'd0, 3'd4};
        cyc();
        chk("byp_on",  32'(rd_data_a[7:0]), 32'h22);
        chk("byp_off", 32'(rd_data_b[7:0]), 32'h11);
        wr_en = 1'b0;
        cyc();
        chk("byp_off_reread", 32'(rd_data_b[7:0]), 32'h22);
        idle_inputs();

        // zero register, both ports hitting the same address
        do_write(3'd0, 8'hFF);
        rd_en = 2'b11; rd_addr = {3'd0, 3'd0};
        cyc();
        chk("zr_off", 32'(rd_data_a), 32'hFFFF);
        chk("zr_on",  32'(rd_data_b), 32'h0000);
        chk("zr_valid", 32'(rd_valid_b), 32'h3);
        idle_inputs();

        // fill, then clear with a same-edge write to r7
        for (int i = 0; i < 8; i++) do_write(3'(i), 8'h10 + 8'(i));
        clr_req = 1'b1; wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'h77;
        cyc();
        idle_inputs();
        sweep_len("sweep1", 1'b1, n);
        for (int i = 0; i < 8; i++) begin
            rd_en = 2'b01; rd_addr = {3'd0, 3'(i)};
            cyc();
            chk("post_clear_a", 32'(rd_data_a[7:0]), 32'h00);
        end
        idle_inputs();

        // reset during the fourth sweep cycle, then a fresh sweep
        do_write(3'd5, 8'h5A);
        clr_req = 1'b1;
        cyc();
        idle_inputs();
        cyc(); cyc(); cyc();
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_busy_a", 32'(clr_busy_a), 32'h0);
        chk("rst_mid_busy_b", 32'(clr_busy_b), 32'h0);
        cyc();
        rst_n = 1'b1;
        rd_en = 2'b01; rd_addr = {3'd0, 3'd5};
        cyc();
        chk("rst_mid_r5", 32'(rd_data_a[7:0]), 32'h00);
        idle_inputs();
        do_write(3'd6, 8'h66);
        clr_req = 1'b1;
        cyc();
        idle_inputs();
        sweep_len("sweep2", 1'b0, n);
        rd_en = 2'b10; rd_addr = {3'd6, 3'd0};
        cyc();
        chk("sweep2_r6", 32'(rd_data_a[15:8]), 32'h00);
        idle_inputs();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
